// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU blocks: multiplier state encoding and a clog2 helper.
package alu_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // Ceiling log2 for sizing counters; values of 0 and 1 need no address bits.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        if (value > 1) begin
            v = value - 1;
            while (v > 0) begin
                result = result + 1;
                v      = v >> 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/unsignedripplecarryadder.sv
// Unsigned ripple-carry adder: sum = a + b + cin, with carry-out.
module unsignedripplecarryadder #(
    parameter int unsigned size = 4
) (
    input  logic [size-1:0] a,
    input  logic [size-1:0] b,
    input  logic            cin,
    output logic [size-1:0] sum,
    output logic            cout
);

    logic [size:0] carry;

    always_comb begin
        carry[0] = cin;
        sum      = '0;
        for (int i = 0; i < int'(size); i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[size];
    end

endmodule

// File: rtl/unsigned_shift_add_multiplier.sv
// Sequential unsigned multiplier: one add-and-shift step per cycle through a shared ripple-carry adder.
// Produces a registered 2*SIZE-bit product SIZE+1 edges after start is accepted.
module unsigned_shift_add_multiplier
    import alu_pkg::*;
#(
    parameter int unsigned SIZE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [SIZE-1:0]     a,
    input  logic [SIZE-1:0]     b,
    output logic                busy,
    output logic                done,
    output logic [2*SIZE-1:0]   product
);

    localparam int unsigned ACC_W = 2 * SIZE;
    localparam int unsigned CNT_W = clog2(SIZE) + 1;

    mul_state_e         state_q, state_d;
    logic [SIZE-1:0]    mcand_q, mcand_d;
    logic [SIZE-1:0]    mplr_q, mplr_d;
    logic [SIZE-1:0]    acc_hi_q, acc_hi_d;
    logic [SIZE-1:0]    acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   product_q, product_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [SIZE-1:0]    addend_c;
    logic [SIZE-1:0]    sum_c;
    logic               cout_c;
    logic [ACC_W-1:0]   acc_next_c;

    assign addend_c = mplr_q[0] ? mcand_q : '0;

    unsignedripplecarryadder #(
        .size (SIZE)
    ) u_adder (
        .a    (acc_hi_q),
        .b    (addend_c),
        .cin  (1'b0),
        .sum  (sum_c),
        .cout (cout_c)
    );

    // Carry-out becomes the new accumulator MSB; acc_lo[0] falls off the bottom.
    assign acc_next_c = ACC_W'({cout_c, sum_c, acc_lo_q} >> 1);

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            MUL_IDLE, MUL_DONE: begin
                if (start) begin
                    mcand_d  = a;
                    mplr_d   = b;
                    acc_hi_d = '0;
                    acc_lo_d = '0;
                    count_d  = '0;
                    state_d  = MUL_RUN;
                end else begin
                    state_d  = MUL_IDLE;
                end
            end
            MUL_RUN: begin
                {acc_hi_d, acc_lo_d} = acc_next_c;
                mplr_d  = mplr_q >> 1;
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(SIZE - 1)) begin
                    product_d = acc_next_c;
                    state_d   = MUL_DONE;
                end
            end
            default: begin
                state_d = MUL_IDLE;
            end
        endcase

        busy_d = (state_d == MUL_RUN);
        done_d = (state_d == MUL_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MUL_IDLE;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_unsigned_shift_add_multiplier.sv
// Self-checking bench for unsigned_shift_add_multiplier (SIZE=4 with cycle model, SIZE=8 directed).
module tb_unsigned_shift_add_multiplier;

    localparam int unsigned SIZE  = 4;
    localparam int unsigned SIZE8 = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  a     = '0;
    logic [3:0]  b     = '0;
    logic        busy;
    logic        done;
    logic [7:0]  product;

    logic        start8 = 1'b0;
    logic [7:0]  a8     = '0;
    logic [7:0]  b8     = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] product8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    unsigned_shift_add_multiplier #(.SIZE(SIZE)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    unsigned_shift_add_multiplier #(.SIZE(SIZE8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start8),
        .a       (a8),
        .b       (b8),
        .busy    (busy8),
        .done    (done8),
        .product (product8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an accepted start yields a*b after SIZE busy cycles.
    int         m_rem     = 0;
    logic       m_busy    = 1'b0;
    logic       m_done    = 1'b0;
    logic [7:0] m_pend    = '0;
    logic [7:0] m_product = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rem     <= 0;
            m_busy    <= 1'b0;
            m_done    <= 1'b0;
            m_pend    <= '0;
            m_product <= '0;
        end else if (m_busy) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_busy    <= 1'b0;
                m_done    <= 1'b1;
                m_product <= m_pend;
            end
        end else if (start) begin
            m_pend <= 8'(a) * 8'(b);
            m_rem  <= int'(SIZE);
            m_busy <= 1'b1;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("busy",          32'(busy),          32'(m_busy));
        check("done",          32'(done),          32'(m_done));
        check("product",       32'(product),       32'(m_product));
        check("busy_done_excl", 32'(busy & done),  32'(0));
        check("busy8_done8_excl", 32'(busy8 & done8), 32'(0));
    end

    // Issue one operation; edges counts the accept edge as 1. poke>0 injects 7*7 start mid-run.
    task automatic do_op(input logic [3:0] ia, input logic [3:0] ib, input int poke,
                         input bit b2b, output int edges, output int busy_cycles);
        int bc;
        bc    = 0;
        edges = -1;
        if (!b2b) begin
            @(posedge clk);
            #1;
        end
        a     = ia;
        b     = ib;
        start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) start = 1'b0;
            if (poke > 0 && n == poke) begin
                a     = 4'd7;
                b     = 4'd7;
                start = 1'b1;
            end
            if (poke > 0 && n == poke + 1) start = 1'b0;
            if (busy) bc++;
            if (done) begin
                edges = n;
                break;
            end
        end
        busy_cycles = bc;
    endtask

    initial begin
        int edges;
        int bc;
        int saw;

        #1 rst_n = 1'b0;
        #2;
        check("rst_busy",    32'(busy),    32'(0));
        check("rst_done",    32'(done),    32'(0));
        check("rst_product", 32'(product), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        do_op(4'd15, 4'd15, 0, 1'b0, edges, bc);
        check("op15x15_edges", 32'(edges),   32'(5));
        check("op15x15_busy",  32'(bc),      32'(4));
        check("op15x15_prod",  32'(product), 32'h0E1);
        repeat (3) @(posedge clk);
        #1;
        check("op15x15_held",  32'(product), 32'd225);

        do_op(4'd13, 4'd11, 0, 1'b0, edges, bc);
        check("op13x11_prod",  32'(product), 32'h08F);
        do_op(4'd0, 4'd13, 0, 1'b0, edges, bc);
        check("op0x13_edges",  32'(edges),   32'(5));
        check("op0x13_prod",   32'(product), 32'd0);

        do_op(4'd6, 4'd5, 2, 1'b0, edges, bc);
        check("ignore_edges",  32'(edges),   32'(5));
        check("ignore_busy",   32'(bc),      32'(4));
        check("ignore_prod",   32'(product), 32'd30);

        // Asynchronous reset two iterations into an operation.
        @(posedge clk);
        #1;
        a     = 4'd12;
        b     = 4'd10;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("midrun_busy",   32'(busy),    32'(1));
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy",    32'(busy),    32'(0));
        check("midrst_done",    32'(done),    32'(0));
        check("midrst_product", 32'(product), 32'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        saw = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw++;
        end
        check("no_done_after_rst", 32'(saw), 32'(0));
        do_op(4'd3, 4'd5, 0, 1'b0, edges, bc);
        check("op3x5_edges",   32'(edges),   32'(5));
        check("op3x5_prod",    32'(product), 32'd15);

        // Back-to-back: new start presented during the DONE cycle.
        do_op(4'd6, 4'd7, 0, 1'b0, edges, bc);
        check("b2b_first_prod", 32'(product), 32'd42);
        do_op(4'd9, 4'd9, 0, 1'b1, edges, bc);
        check("b2b_edges",     32'(edges),   32'(5));
        check("b2b_busy",      32'(bc),      32'(4));
        check("b2b_prod",      32'(product), 32'd81);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                do_op(4'(i), 4'(j), 0, 1'b0, edges, bc);
                check("sweep_edges", 32'(edges),   32'(5));
                check("sweep_prod",  32'(product), 32'(i * j));
            end
        end

        // SIZE=8 directed operations.
        begin
            logic [7:0]  xa [2];
            logic [7:0]  xb [2];
            logic [15:0] xp [2];
            xa[0] = 8'd255; xb[0] = 8'd255; xp[0] = 16'hFE01;
            xa[1] = 8'd200; xb[1] = 8'd3;   xp[1] = 16'd600;
            for (int t = 0; t < 2; t++) begin
                @(posedge clk);
                #1;
                a8     = xa[t];
                b8     = xb[t];
                start8 = 1'b1;
                edges  = -1;
                bc     = 0;
                for (int n = 1; n <= 30; n++) begin
                    @(posedge clk);
                    #1;
                    if (n == 1) start8 = 1'b0;
                    if (busy8) bc++;
                    if (done8) begin
                        edges = n;
                        break;
                    end
                end
                check("size8_edges", 32'(edges),    32'(9));
                check("size8_busy",  32'(bc),       32'(8));
                check("size8_prod",  32'(product8), 32'(xp[t]));
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
